// File: rtl/oq_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : oq_rr_scheduler
// Description : Round-robin output-queue scheduler. Picks the next eligible
//               queue (non-empty, enabled, port ready) after the last winner,
//               offers it to the packet-removal engine and holds the grant
//               until the packet has been fully removed.
//               Optional BUSY watchdog: define OQ_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oq_rr_scheduler #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_PORTS         = 2,
    parameter int WATCHDOG_CYCLES   = 4096,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sched_en,
    input  logic [NUM_OUTPUT_QUEUES-1:0] oq_empty,
    input  logic [NUM_OUTPUT_QUEUES-1:0] enable_send_pkt,
    input  logic [NUM_PORTS-1:0]         port_rdy,
    output logic                         grant_vld,
    output logic [NUM_OQ_WIDTH-1:0]      grant_oq,
    input  logic                         grant_ack,
    input  logic                         pkt_done,
    output logic                         sched_busy,
    output logic                         sched_timeout
);

    localparam logic [NUM_OQ_WIDTH-1:0] c_LAST_OQ = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);
    localparam logic [NUM_OQ_WIDTH-1:0] c_ONE_OQ  = NUM_OQ_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_issue;
    logic [NUM_OUTPUT_QUEUES-1:0]   w_elig;
    logic                           w_found;
    logic [NUM_OQ_WIDTH-1:0]        w_winner;
    logic [NUM_OQ_WIDTH-1:0]        w_idx;
    logic [NUM_OQ_WIDTH-1:0]        r_grant_oq;
    logic [NUM_OQ_WIDTH-1:0]        r_last_oq;

    // Per-queue eligibility; queue q is served by port q mod NUM_PORTS.
    genvar q;
    generate
        for (q = 0; q < NUM_OUTPUT_QUEUES; q++) begin : g_elig
            assign w_elig[q] = ~oq_empty[q] & enable_send_pkt[q] & port_rdy[q % NUM_PORTS];
        end
    endgenerate

    // Search from last_oq+1 upwards with an explicit wrap so non-power-of-two
    // queue counts never index past the last queue.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_oq;
        w_idx    = (r_last_oq == c_LAST_OQ) ? '0 : r_last_oq + c_ONE_OQ;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
            w_idx = (w_idx == c_LAST_OQ) ? '0 : w_idx + c_ONE_OQ;
        end
    end

`ifdef OQ_SCHED_WATCHDOG_EN
    localparam int                c_WD_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;
    logic              w_expire;
`else
    // Keeps the watchdog depth parameter referenced in the default build.
    if (WATCHDOG_CYCLES < 1) begin : g_wd_cfg_invalid
    end
`endif

    // Next-state decode; a grant, once issued, ignores eligibility and enable.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
`ifdef OQ_SCHED_WATCHDOG_EN
        w_expire    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (sched_en && w_found) begin
                    w_state_nxt = S_GRANT;
                    w_issue     = 1'b1;
                end
            end
            S_GRANT: begin
                if (grant_ack) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (pkt_done) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef OQ_SCHED_WATCHDOG_EN
                else if (r_wd_cnt == c_WD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_expire    = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winner and advance the round-robin pointer on each grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_oq <= '0;
            r_last_oq  <= c_LAST_OQ;
        end else if (w_issue) begin
            r_grant_oq <= w_winner;
            r_last_oq  <= w_winner;
        end
    end

`ifdef OQ_SCHED_WATCHDOG_EN
    // BUSY-cycle counter and one-cycle timeout pulse; pkt_done on the expiry
    // cycle takes priority because it is decoded ahead of expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == S_GRANT && grant_ack) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            end
        end
    end

    assign sched_timeout = r_timeout;
`else
    assign sched_timeout = 1'b0;
`endif

    assign grant_vld  = (r_state == S_GRANT);
    assign grant_oq   = r_grant_oq;
    assign sched_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oq_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_oq_rr_scheduler
// Description : Directed self-checking bench for oq_rr_scheduler (8 queues,
//               2 ports, watchdog depth 16 when OQ_SCHED_WATCHDOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oq_rr_scheduler;

    logic       clk;
    logic       reset;
    logic       sched_en;
    logic [7:0] oq_empty;
    logic [7:0] enable_send_pkt;
    logic [1:0] port_rdy;
    logic       grant_vld;
    logic [2:0] grant_oq;
    logic       grant_ack;
    logic       pkt_done;
    logic       sched_busy;
    logic       sched_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    oq_rr_scheduler #(
        .NUM_OUTPUT_QUEUES (8),
        .NUM_PORTS         (2),
        .WATCHDOG_CYCLES   (16),
        .NUM_OQ_WIDTH      (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sched_en        (sched_en),
        .oq_empty        (oq_empty),
        .enable_send_pkt (enable_send_pkt),
        .port_rdy        (port_rdy),
        .grant_vld       (grant_vld),
        .grant_oq        (grant_oq),
        .grant_ack       (grant_ack),
        .pkt_done        (pkt_done),
        .sched_busy      (sched_busy),
        .sched_timeout   (sched_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Accept the current grant, then complete the packet; ends in IDLE.
    task automatic finish_pkt();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        pkt_done  = 1'b1;
        tick();
        pkt_done  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; sched_en = 1'b0; oq_empty = 8'hFF;
        enable_send_pkt = 8'hFF; port_rdy = 2'b11;
        grant_ack = 1'b0; pkt_done = 1'b0;
        ticks(2);
        n_checks++; if (grant_vld !== 1'b0) $display("FAIL reset_grant_vld: got %b expected 0", grant_vld); else n_pass++;
        n_checks++; if (grant_oq !== 3'd0) $display("FAIL reset_grant_oq: got %0d expected 0", grant_oq); else n_pass++;
        n_checks++; if (sched_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", sched_busy); else n_pass++;
        n_checks++; if (sched_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", sched_timeout); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        oq_empty = 8'hF5; sched_en = 1'b1;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd1) $display("FAIL rr_first: got vld=%b oq=%0d expected vld=1 oq=1", grant_vld, grant_oq); else n_pass++;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        n_checks++; if (grant_vld !== 1'b0 || sched_busy !== 1'b1) $display("FAIL rr_busy: got vld=%b busy=%b expected vld=0 busy=1", grant_vld, sched_busy); else n_pass++;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        n_checks++; if (grant_vld !== 1'b0 || sched_busy !== 1'b0) $display("FAIL rr_idle_gap: got vld=%b busy=%b expected vld=0 busy=0", grant_vld, sched_busy); else n_pass++;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd3) $display("FAIL rr_second: got vld=%b oq=%0d expected vld=1 oq=3", grant_vld, grant_oq); else n_pass++;
        finish_pkt();
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd1) $display("FAIL rr_third: got vld=%b oq=%0d expected vld=1 oq=1", grant_vld, grant_oq); else n_pass++;
        oq_empty = 8'hFF;
        finish_pkt();
    endtask

    task automatic test_masking();
        oq_empty = 8'hFB; enable_send_pkt = 8'hFB;
        ticks(3);
        n_checks++; if (grant_vld !== 1'b0) $display("FAIL mask_enable: got vld=%b expected 0", grant_vld); else n_pass++;
        enable_send_pkt = 8'hFF; port_rdy = 2'b10;
        ticks(3);
        n_checks++; if (grant_vld !== 1'b0) $display("FAIL mask_port: got vld=%b expected 0", grant_vld); else n_pass++;
        port_rdy = 2'b11;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd2) $display("FAIL mask_restore: got vld=%b oq=%0d expected vld=1 oq=2", grant_vld, grant_oq); else n_pass++;
        oq_empty = 8'hFF;
        finish_pkt();
    endtask

    task automatic test_committed();
        oq_empty = 8'hDF;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd5) $display("FAIL commit_grant: got vld=%b oq=%0d expected vld=1 oq=5", grant_vld, grant_oq); else n_pass++;
        oq_empty = 8'hFF; sched_en = 1'b0;
        ticks(3);
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd5) $display("FAIL commit_hold: got vld=%b oq=%0d expected vld=1 oq=5", grant_vld, grant_oq); else n_pass++;
        finish_pkt();
        oq_empty = 8'hDF;
        ticks(3);
        n_checks++; if (grant_vld !== 1'b0 || sched_busy !== 1'b0) $display("FAIL commit_disabled: got vld=%b busy=%b expected vld=0 busy=0", grant_vld, sched_busy); else n_pass++;
        oq_empty = 8'hFF; sched_en = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        oq_empty = 8'hBF;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd6) $display("FAIL b2b_grant: got vld=%b oq=%0d expected vld=1 oq=6", grant_vld, grant_oq); else n_pass++;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        n_checks++; if (grant_vld !== 1'b1 || sched_busy !== 1'b1) $display("FAIL b2b_spurious_done: got vld=%b busy=%b expected vld=1 busy=1", grant_vld, sched_busy); else n_pass++;
        finish_pkt();
        n_checks++; if (grant_vld !== 1'b0) $display("FAIL b2b_gap1: got vld=%b expected 0", grant_vld); else n_pass++;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd6) $display("FAIL b2b_regrant: got vld=%b oq=%0d expected vld=1 oq=6", grant_vld, grant_oq); else n_pass++;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        n_checks++; if (grant_vld !== 1'b0 || sched_busy !== 1'b1) $display("FAIL b2b_first_cycle_ack: got vld=%b busy=%b expected vld=0 busy=1", grant_vld, sched_busy); else n_pass++;
        oq_empty = 8'hFF;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        oq_empty = 8'h7E;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd7) $display("FAIL wrap_first: got vld=%b oq=%0d expected vld=1 oq=7", grant_vld, grant_oq); else n_pass++;
        finish_pkt();
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd0) $display("FAIL wrap_second: got vld=%b oq=%0d expected vld=1 oq=0", grant_vld, grant_oq); else n_pass++;
        finish_pkt();
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd7) $display("FAIL wrap_third: got vld=%b oq=%0d expected vld=1 oq=7", grant_vld, grant_oq); else n_pass++;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (sched_busy !== 1'b0 || grant_vld !== 1'b0 || grant_oq !== 3'd0) $display("FAIL async_reset: got busy=%b vld=%b oq=%0d expected busy=0 vld=0 oq=0", sched_busy, grant_vld, grant_oq); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd0) $display("FAIL post_reset_ptr: got vld=%b oq=%0d expected vld=1 oq=0", grant_vld, grant_oq); else n_pass++;
    endtask

`ifdef OQ_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        oq_empty = 8'hCF;
        finish_pkt();
        tick();
        n_checks++; if (grant_vld !== 1'b1 || grant_oq !== 3'd4) $display("FAIL wd_grant: got vld=%b oq=%0d expected vld=1 oq=4", grant_vld, grant_oq); else n_pass++;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        ticks(15);
        n_checks++; if (sched_busy !== 1'b1 || sched_timeout !== 1'b0) $display("FAIL wd_before: got busy=%b to=%b expected busy=1 to=0", sched_busy, sched_timeout); else n_pass++;
        tick();
        n_checks++; if (sched_busy !== 1'b0 || sched_timeout !== 1'b1) $display("FAIL wd_expire: got busy=%b to=%b expected busy=0 to=1", sched_busy, sched_timeout); else n_pass++;
        tick();
        n_checks++; if (sched_timeout !== 1'b0 || grant_vld !== 1'b1 || grant_oq !== 3'd5) $display("FAIL wd_next: got to=%b vld=%b oq=%0d expected to=0 vld=1 oq=5", sched_timeout, grant_vld, grant_oq); else n_pass++;
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        ticks(15);
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        n_checks++; if (sched_busy !== 1'b0 || sched_timeout !== 1'b0) $display("FAIL wd_done_wins: got busy=%b to=%b expected busy=0 to=0", sched_busy, sched_timeout); else n_pass++;
        tick();
        n_checks++; if (sched_timeout !== 1'b0) $display("FAIL wd_no_pulse: got to=%b expected 0", sched_timeout); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_committed();
        test_back_to_back();
        test_wrap_and_reset();
`ifdef OQ_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/oq_rr_scheduler.md
# oq_rr_scheduler

Round-robin scheduler that chooses which output queue the packet-removal engine services next. It sits between the output-queue registers (per-queue empty and enable flags), the output ports (ready flags) and `remove_pkt_2`. It issues one queue grant at a time and holds it until the whole packet has been removed. Fairness is strict round-robin over queues that are non-empty, enabled and whose port is ready.

## Interface
- `NUM_OUTPUT_QUEUES`, 8: number of queues arbitrated; any value ≥2.
- `NUM_PORTS`, 2: number of output ports; queue q drives port q mod `NUM_PORTS`.
- `WATCHDOG_CYCLES`, 4096: BUSY timeout, used only with the watchdog macro; must be ≥1.
- `NUM_OQ_WIDTH`, log2(`NUM_OUTPUT_QUEUES`): queue index width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset asserted.
- `sched_en`  in  1  global enable; 0 blocks new grants only.
- `oq_empty`  in  `NUM_OUTPUT_QUEUES`  per-queue empty flag.
- `enable_send_pkt`  in  `NUM_OUTPUT_QUEUES`  per-queue send enable.
- `port_rdy`  in  `NUM_PORTS`  output port can accept data.
- `grant_vld`  out  1  a grant is offered.
- `grant_oq`  out  `NUM_OQ_WIDTH`  granted queue index.
- `grant_ack`  in  1  removal engine accepts the grant.
- `pkt_done`  in  1  one-cycle pulse: granted packet fully removed.
- `sched_busy`  out  1  high in GRANT and BUSY.
- `sched_timeout`  out  1  one-cycle pulse on watchdog abort; tied to 0 without the macro.

## Operation
- Eligibility: `elig[q] = !oq_empty[q] & enable_send_pkt[q] & port_rdy[q mod NUM_PORTS]`.
- Pointer `last_oq`: search starts at `last_oq+1` and visits queues in ascending order. After index `NUM_OUTPUT_QUEUES-1` it wraps explicitly to 0; there is no modulo on non-power-of-two counts.
- The first eligible queue in search order wins. `last_oq` updates to the winner only when a grant is issued.
- States:
  - IDLE: if `sched_en` and any `elig`, register the winner into `grant_oq`, update `last_oq`, go to GRANT. Otherwise stay.
  - GRANT: `grant_vld`=1. On `grant_ack`, go to BUSY. The grant is committed: later changes to `elig` or `sched_en` are ignored until it completes.
  - BUSY: wait for `pkt_done`, then go to IDLE. With the watchdog, also go to IDLE on timeout.
- `pkt_done` outside BUSY is ignored. `grant_ack` outside GRANT is ignored.
- `grant_oq` holds its last value outside GRANT and BUSY.
- Reset mid-operation: all state returns to reset values immediately, including any grant in flight. The removal engine is reset with the same signal.

## Timing
- Reset values: state IDLE, `grant_vld`=0, `grant_oq`=0, `sched_busy`=0, `sched_timeout`=0, `last_oq`=`NUM_OUTPUT_QUEUES-1` (so the first search starts at queue 0), watchdog counter 0.
- Grant latency: an eligible queue sampled in IDLE at edge N gives `grant_vld`=1 from edge N+1.
- `grant_ack` may be asserted in the first GRANT cycle. BUSY then starts the next cycle, and `grant_vld` falls the same edge.
- `pkt_done` at edge M gives IDLE at M+1. The earliest next `grant_vld` is M+2, so there are at least 2 cycles between grants.
- `grant_vld` and `grant_oq` are registered with no combinational path from inputs. `sched_busy` is decoded from registered state.

## Configuration
- `OQ_SCHED_WATCHDOG_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `WATCHDOG_CYCLES` without `pkt_done`: go to IDLE, pulse `sched_timeout` for one cycle, keep `last_oq` advanced past the aborted queue.
  - `pkt_done` in the same cycle as expiry wins: no timeout pulse.
- `OQ_SCHED_WATCHDOG_EN` undefined: no counter, BUSY waits indefinitely, `sched_timeout` is constant 0.

## Test plan
- Reset release, N=8: `oq_empty`=8'hF5 (queues 1 and 3 non-empty), all enabled, ports ready → first grant is `grant_oq`=1. Ack, `pkt_done` → next grant is 3, then 1 again.
- Eligibility masking: queue 2 non-empty with `enable_send_pkt[2]`=0, or queue 2 non-empty with `port_rdy[0]`=0 → queue 2 is never granted. Restoring the enable gives a grant to 2 within 2 cycles.
- Committed grant: grant 5 issued, then `oq_empty[5]`=1 and `sched_en`=0 before `grant_ack` → `grant_vld` stays high with `grant_oq`=5 until ack. After `pkt_done`, no new grant while `sched_en`=0.
- Spurious and back-to-back inputs: `pkt_done` pulsed in GRANT → ignored, state stays GRANT. Ack in the first GRANT cycle plus `pkt_done` the next cycle → `grant_vld` reasserts exactly 2 cycles after `pkt_done`.
- Wrap and asynchronous reset: only queues 7 and 0 eligible → grants alternate 7, 0, 7. `reset`=0 asserted mid-BUSY → `sched_busy` and `grant_vld` go to 0 without waiting for a clock edge.
- Watchdog (macro on, `WATCHDOG_CYCLES`=16): grant 4, ack, no `pkt_done` → `sched_timeout` pulses after 16 BUSY cycles, then the next grant goes to the queue after 4. Repeat with `pkt_done` on the expiry cycle → no timeout pulse.
